// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master sending and receiving one DATA_W-bit MSB-first frame per start
module spi_master #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs_n
);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(DATA_W + 1);
   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
   logic              sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              tick;
   assign tick = div_q == DIV_W'(CLK_DIV - 1);
   always_comb begin
      state_d = state_q;
      div_d   = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
      bit_d   = bit_q;
      tx_sh_d = tx_sh_q;
      rx_sh_d = rx_sh_q;
      rx_d    = rx_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = SETUP;
            tx_sh_d = tx_data;
            rx_sh_d = '0;
            bit_d   = '0;
            mosi_d  = tx_data[DATA_W-1];
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
         end
         SETUP: if (tick) begin
            state_d = XFER;
            sclk_d  = 1'b1;
            rx_sh_d = DATA_W'({rx_sh_q, miso});
         end
         XFER: if (tick) begin
            sclk_d = !sclk_q;
            // rising half samples miso; falling half advances mosi unless it was the last bit
            if (!sclk_q) rx_sh_d = DATA_W'({rx_sh_q, miso});
            else if (bit_q == BIT_W'(DATA_W - 1)) state_d = HOLD;
            else begin
               bit_d   = bit_q + 1'b1;
               tx_sh_d = tx_sh_q << 1;
               mosi_d  = tx_sh_d[DATA_W-1];
            end
         end
         HOLD: if (tick) begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rx_d    = rx_sh_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         tx_sh_q <= '0;
         rx_sh_q <= '0;
         rx_q    <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         tx_sh_q <= tx_sh_d;
         rx_sh_q <= rx_sh_d;
         rx_q    <= rx_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign cs_n    = cs_n_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: random and directed frames on two spi_master configurations, checked every cycle against a timing-formula model
module tb_spi_master;
   localparam int DW0 = 8, CD0 = 4, T0 = (2 * DW0 + 1) * CD0;
   localparam int DW1 = 16, CD1 = 1, T1 = (2 * DW1 + 1) * CD1;
   logic clk = 1'b0, reset_n = 1'b0;
   logic start0 = 1'b0, start1 = 1'b0;
   logic [7:0] tx0 = '0, rx0;
   logic [15:0] tx1 = '0, rx1;
   logic busy0, done0, sclk0, mosi0, cs_n0, miso0;
   logic busy1, done1, sclk1, mosi1, cs_n1;
   logic miso_s = 1'b0, miso_r = 1'b0, mosi_prev = 1'b0;
   logic [7:0] s_tx = '0, s_rx = '0;
   int s_bit = 0, mode = 0, rise_cnt = 0, done_cnt0 = 0;
   int checks = 0, errors = 0;
   int t0 = -1, t1 = -1;
   logic [7:0] tx_m0 = '0, rx_m0 = '0, acc0 = '0;
   logic [15:0] tx_m1 = '0, rx_m1 = '0, acc1 = '0;
   always #5 clk = ~clk;
   assign miso0 = mode == 0 ? mosi0 : mode == 1 ? miso_s : miso_r;
   spi_master u0 (.clk(clk), .reset_n(reset_n), .start(start0), .tx_data(tx0), .busy(busy0), .done(done0),
                  .rx_data(rx0), .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(cs_n0));
   spi_master #(.DATA_W(DW1), .CLK_DIV(CD1)) u1 (.clk(clk), .reset_n(reset_n), .start(start1), .tx_data(tx1),
                  .busy(busy1), .done(done1), .rx_data(rx1), .sclk(sclk1), .mosi(mosi1), .miso(mosi1), .cs_n(cs_n1));
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual %h expected %h at %0t", n, a, e, $time);
      end
   endtask
   // t = clk edges since the accepting edge; sclk high during [CD+2k*CD, 2CD+2k*CD) for bit k
   function automatic logic f_sclk(input int t, input int dw, input int cd);
      return t >= cd && (t - cd) / (2 * cd) < dw && (t - cd) % (2 * cd) < cd;
   endfunction
   function automatic logic f_mosi(input int t, input int dw, input int cd, input logic [15:0] tx);
      int k = t / (2 * cd);
      if (k > dw - 1) k = dw - 1;
      return tx[dw-1-k];
   endfunction
   function automatic logic f_rise(input int t, input int dw, input int cd);
      return t >= cd && (t - cd) % (2 * cd) == 0 && (t - cd) / (2 * cd) < dw;
   endfunction
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t0 = -1;
         rx_m0 = '0;
      end else if ((t0 == -1 || t0 == T0) && start0) begin
         t0 = 0;
         tx_m0 = tx0;
         acc0 = '0;
      end else if (t0 >= 0 && t0 < T0) begin
         t0++;
         if (f_rise(t0, DW0, CD0)) acc0 = {acc0[6:0], miso0};
         if (t0 == T0) rx_m0 = acc0;
      end else t0 = -1;
   end
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t1 = -1;
         rx_m1 = '0;
      end else if ((t1 == -1 || t1 == T1) && start1) begin
         t1 = 0;
         tx_m1 = tx1;
         acc1 = '0;
      end else if (t1 >= 0 && t1 < T1) begin
         t1++;
         if (f_rise(t1, DW1, CD1)) acc1 = {acc1[14:0], mosi1};
         if (t1 == T1) rx_m1 = acc1;
      end else t1 = -1;
   end
   always @(negedge clk) begin
      mosi_prev = mosi0;
      if (done0) done_cnt0++;
      if (reset_n) begin
         chk("cyc0", {cs_n0, busy0, done0, sclk0, mosi0, rx0}, (t0 >= 0 && t0 < T0) ?
             {1'b0, 1'b1, 1'b0, f_sclk(t0, DW0, CD0), f_mosi(t0, DW0, CD0, {8'h00, tx_m0}), rx_m0} :
             {1'b1, 1'b0, (t0 == T0), 1'b0, 1'b0, rx_m0});
         chk("cyc1", {cs_n1, busy1, done1, sclk1, mosi1, rx1}, (t1 >= 0 && t1 < T1) ?
             {1'b0, 1'b1, 1'b0, f_sclk(t1, DW1, CD1), f_mosi(t1, DW1, CD1, tx_m1), rx_m1} :
             {1'b1, 1'b0, (t1 == T1), 1'b0, 1'b0, rx_m1});
      end
   end
   always @(negedge clk) miso_r = 1'($urandom);
   // mode-0 slave: presents MSB at cs_n fall, shifts out on sclk fall, captures on sclk rise
   always @(negedge cs_n0) begin
      s_bit = 7;
      miso_s = s_tx[7];
      s_rx = '0;
   end
   always @(posedge sclk0) begin
      s_rx = {s_rx[6:0], mosi0};
      if (!cs_n0) rise_cnt++;
      chk("mosi_stable", mosi0, mosi_prev);
   end
   always @(negedge sclk0) if (s_bit > 0) begin
      s_bit--;
      miso_s = s_tx[s_bit];
   end
   task automatic go0(input logic [7:0] d, input int m, input int ign, output int cyc);
      mode = m;
      start0 = 1'b1;
      tx0 = d;
      rise_cnt = 0;
      @(negedge clk);
      start0 = 1'b0;
      tx0 = 8'($urandom);
      cyc = 1;
      chk("cs_fall", cs_n0, 1'b0);
      while (!done0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start0 = ign > 0 && cyc == ign;
         if (start0) tx0 = 8'hFF;
      end
      start0 = 1'b0;
      chk("done_cyc", cyc, 69);
      chk("sclk_rises", rise_cnt, 8);
   endtask
   task automatic go1(input logic [15:0] d);
      int cyc;
      start1 = 1'b1;
      tx1 = d;
      @(negedge clk);
      start1 = 1'b0;
      tx1 = 16'($urandom);
      cyc = 1;
      while (!done1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_cyc16", cyc, 34);
      chk("rx16", rx1, d);
   endtask
   initial begin
      int c, dc, m, ign;
      logic [7:0] d;
      repeat (3) @(negedge clk);
      #1 chk("reset0", {cs_n0, busy0, done0, sclk0, mosi0, rx0}, 13'h1000);
      chk("reset1", {cs_n1, busy1, done1, sclk1, mosi1, rx1}, 21'h100000);
      #1 reset_n = 1'b1;
      @(negedge clk);
      go0(8'hA5, 0, 0, c);
      chk("loop_a5", rx0, 8'hA5);
      @(negedge clk);
      s_tx = 8'h3C;
      go0(8'hC3, 1, 0, c);
      chk("slave_rx", rx0, 8'h3C);
      chk("slave_cap", s_rx, 8'hC3);
      @(negedge clk);
      dc = done_cnt0;
      go0(8'h81, 0, 10, c);
      repeat (80) @(negedge clk);
      chk("ign_rx", rx0, 8'h81);
      chk("ign_dones", done_cnt0 - dc, 1);
      go0(8'h33, 0, 0, c);
      chk("b2b_cs_hi", cs_n0, 1'b1);
      go0(8'h5A, 0, 0, c);
      chk("b2b_rx", rx0, 8'h5A);
      @(negedge clk);
      mode = 0;
      start0 = 1'b1;
      tx0 = 8'hE7;
      @(negedge clk);
      start0 = 1'b0;
      repeat (29) @(negedge clk);
      dc = done_cnt0;
      #2 reset_n = 1'b0;
      #1 chk("rst_mid", {cs_n0, sclk0, busy0, done0, mosi0, rx0}, 13'h1000);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (75) @(negedge clk);
      chk("rst_no_done", done_cnt0 - dc, 0);
      go0(8'h96, 0, 0, c);
      chk("post_rst_rx", rx0, 8'h96);
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(1, 4)) @(negedge clk);
         d = 8'($urandom);
         m = $urandom_range(0, 2);
         s_tx = 8'($urandom);
         ign = $urandom_range(0, 1) == 1 ? $urandom_range(2, 60) : 0;
         go0(d, m, ign, c);
         if (m == 0) chk("rnd_loop", rx0, d);
         else if (m == 1) begin
            chk("rnd_slave_rx", rx0, s_tx);
            chk("rnd_slave_cap", s_rx, d);
         end else chk("rnd_miso", rx0, rx_m0);
      end
      @(negedge clk);
      go1(16'h8001);
      @(negedge clk);
      go1(16'($urandom));
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
